// File: rtl/rca_seq_adder.sv
// Sequential ripple-carry adder: one 4-bit slice per clock, IDLE -> RUN -> DONE.
// Defining RCA_SEQ_ADDER_OVF_EN adds the Ovf output (signed overflow of the top slice).
module rca_seq_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] A,
   input  logic [4*NIBBLES-1:0] B,
   input  logic                 Cin,
   output logic [4*NIBBLES-1:0] Sum,
   output logic                 Cout,
`ifdef RCA_SEQ_ADDER_OVF_EN
   output logic                 Ovf,
`endif
   output logic                 busy,
   output logic                 done
);
   localparam int W = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [W-1:0]     a_reg;
   logic [W-1:0]     b_reg;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [4:0]       slice;

   // The slice selected by idx feeds a single shared 4-bit adder.
   assign a_nib = a_reg[{idx, 2'b00} +: 4];
   assign b_nib = b_reg[{idx, 2'b00} +: 4];
   assign slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_reg <= '0;
         b_reg <= '0;
         idx   <= '0;
         carry <= 1'b0;
         Sum   <= '0;
         Cout  <= 1'b0;
`ifdef RCA_SEQ_ADDER_OVF_EN
         Ovf   <= 1'b0;
`endif
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= A;
                  b_reg <= B;
                  carry <= Cin;
                  Sum   <= '0;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               Sum[{idx, 2'b00} +: 4] <= slice[3:0];
               carry <= slice[4];
               if (idx == LAST_IDX) begin
                  idx   <= '0;
                  Cout  <= slice[4];
`ifdef RCA_SEQ_ADDER_OVF_EN
                  // Carry into the MSB is recovered as a^b^sum of bit 3.
                  Ovf   <= a_nib[3] ^ b_nib[3] ^ slice[3] ^ slice[4];
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
